// File: rtl/dummy_ctrl_gen.sv
// Run controller: optional millisecond delay, then copies LEN words from the input memory
// through a selectable transform into the output memory, with host status flags.
module dummy_ctrl_gen #(
  parameter int ADDR_WIDTH_MEMI = 6,
  parameter int ADDR_WIDTH_MEMO = 6,
  parameter int SIZE_CR         = 2,
  parameter int TICKS_PER_MS    = 50000,
  parameter int RD_LAT          = 1
) (
  input  logic                       clk,
  input  logic                       rst_a,
  input  logic                       en_s,
  input  logic                       start,
  input  logic                       abort,
  input  logic [SIZE_CR*32-1:0]      confReg,
  output logic [ADDR_WIDTH_MEMI-1:0] addrRD,
  input  logic [31:0]                dataRD,
  output logic [ADDR_WIDTH_MEMO-1:0] addrWR,
  output logic [31:0]                dataWR,
  output logic                       enWR,
  output logic                       busy_f,
  output logic                       done_f,
  output logic                       data_rdy,
  output logic                       data_read,
  output logic                       err_f
);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_DELAY   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WRITE   = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH_I   = 17'(2 ** ADDR_WIDTH_MEMI);
  localparam logic [16:0] DEPTH_O   = 17'(2 ** ADDR_WIDTH_MEMO);
  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_MS - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(RD_LAT - 1);

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH_MEMI-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_WIDTH_MEMO-1:0] addr_wr_q, addr_wr_d;
  logic                       en_wr_q, en_wr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       data_read_q, data_read_d;
  logic                       data_rdy_q, data_rdy_d;
  logic                       err_q, err_d;
  logic [31:0]                tick_q, tick_d;
  logic [30:0]                ms_q, ms_d;
  logic [2:0]                 lat_q, lat_d;
  logic [16:0]                cnt_q, cnt_d;
  logic [30:0]                delay_ms_q, delay_ms_d;
  logic [16:0]                len_q, len_d;
  logic [7:0]                 rdy_thr_q, rdy_thr_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       state_bad;
  logic [16:0]                len_cfg;
  logic                       cfg_unused;

  // A zero length field selects the full output memory depth.
  assign len_cfg    = (confReg[47:32] == 16'd0) ? DEPTH_O : {1'b0, confReg[47:32]};
  assign cfg_unused = ^confReg[SIZE_CR*32-1:58];

  function automatic logic [31:0] xform(input logic [1:0] m, input logic [31:0] d);
    case (m)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return d + 32'd1;
      default: return {d[15:0], d[31:16]};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_rd_d   = addr_rd_q;
    addr_wr_d   = addr_wr_q;
    en_wr_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    data_read_d = 1'b0;
    data_rdy_d  = data_rdy_q;
    err_d       = err_q;
    tick_d      = tick_q;
    ms_d        = ms_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    delay_ms_d  = delay_ms_q;
    len_d       = len_q;
    rdy_thr_d   = rdy_thr_q;
    mode_d      = mode_q;
    state_bad   = 1'b0;
    case (state_q)
      ST_STANDBY: begin
        if (start) begin
          state_d    = ST_CONFIG;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          data_rdy_d = 1'b0;
        end
      end
      ST_CONFIG: begin
        delay_ms_d = confReg[31:1];
        len_d      = len_cfg;
        rdy_thr_d  = confReg[55:48];
        mode_d     = confReg[57:56];
        if (len_cfg > DEPTH_I || len_cfg > DEPTH_O) begin
          state_d = ST_STANDBY;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (confReg[0]) begin
          state_d = ST_DELAY;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_DELAY: begin
        if (ms_q == delay_ms_q) begin
          state_d = ST_RD_WAIT;
          tick_d  = 32'd0;
          ms_d    = 31'd0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = 32'd0;
          ms_d   = ms_q + 31'd1;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = 3'd0;
          state_d = ST_WRITE;
          en_wr_d = 1'b1;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        cnt_d = cnt_q + 17'd1;
        if (rdy_thr_q != 8'd0 && cnt_d == {9'd0, rdy_thr_q}) data_rdy_d = 1'b1;
        if (cnt_d == len_q) begin
          state_d     = ST_STANDBY;
          done_d      = 1'b1;
          data_read_d = 1'b1;
          busy_d      = 1'b0;
          addr_rd_d   = '0;
          addr_wr_d   = '0;
          cnt_d       = 17'd0;
        end else begin
          addr_rd_d = addr_rd_q + ADDR_WIDTH_MEMI'(1);
          addr_wr_d = addr_wr_q + ADDR_WIDTH_MEMO'(1);
          state_d   = ST_RD_WAIT;
        end
      end
      default: state_bad = 1'b1;
    endcase
    // Abort overrides whatever transition the state logic picked this cycle.
    if (state_bad || (abort && state_q != ST_STANDBY)) begin
      state_d     = ST_STANDBY;
      addr_rd_d   = '0;
      addr_wr_d   = '0;
      en_wr_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      data_read_d = 1'b0;
      data_rdy_d  = 1'b0;
      tick_d      = 32'd0;
      ms_d        = 31'd0;
      lat_d       = 3'd0;
      cnt_d       = 17'd0;
      if (state_bad) err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= ST_STANDBY;
      addr_rd_q   <= '0;
      addr_wr_q   <= '0;
      en_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_read_q <= 1'b0;
      data_rdy_q  <= 1'b0;
      err_q       <= 1'b0;
      tick_q      <= 32'd0;
      ms_q        <= 31'd0;
      lat_q       <= 3'd0;
      cnt_q       <= 17'd0;
      delay_ms_q  <= 31'd0;
      len_q       <= 17'd0;
      rdy_thr_q   <= 8'd0;
      mode_q      <= 2'd0;
    end else if (en_s) begin
      state_q     <= state_d;
      addr_rd_q   <= addr_rd_d;
      addr_wr_q   <= addr_wr_d;
      en_wr_q     <= en_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_read_q <= data_read_d;
      data_rdy_q  <= data_rdy_d;
      err_q       <= err_d;
      tick_q      <= tick_d;
      ms_q        <= ms_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      delay_ms_q  <= delay_ms_d;
      len_q       <= len_d;
      rdy_thr_q   <= rdy_thr_d;
      mode_q      <= mode_d;
    end
  end

  // Read data arrives during WRITE, so the transform sits on the read path.
  assign dataWR    = en_wr_q ? xform(mode_q, dataRD) : 32'd0;
  assign addrRD    = addr_rd_q;
  assign addrWR    = addr_wr_q;
  assign enWR      = en_wr_q;
  assign busy_f    = busy_q;
  assign done_f    = done_q;
  assign data_rdy  = data_rdy_q;
  assign data_read = data_read_q;
  assign err_f     = err_q;

endmodule

// File: tb/tb_dummy_ctrl_gen.sv
// Bench for dummy_ctrl_gen: timing-formula model checked every cycle plus literal run checks.
module tb_dummy_ctrl_gen;
  localparam int RD_LAT = 1;
  localparam int TPM    = 10;

  logic        clk, rst_a, en_s, start, abort;
  logic [63:0] confReg;
  logic [5:0]  addrRD, addrWR;
  logic [31:0] dataRD, dataWR;
  logic        enWR, busy_f, done_f, data_rdy, data_read, err_f;

  dummy_ctrl_gen #(.ADDR_WIDTH_MEMI(6), .ADDR_WIDTH_MEMO(6), .SIZE_CR(2),
                   .TICKS_PER_MS(TPM), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .abort(abort),
    .confReg(confReg), .addrRD(addrRD), .dataRD(dataRD), .addrWR(addrWR),
    .dataWR(dataWR), .enWR(enWR), .busy_f(busy_f), .done_f(done_f),
    .data_rdy(data_rdy), .data_read(data_read), .err_f(err_f));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Input memory with RD_LAT-cycle registered read.
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[addrRD];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dataRD = rd_pipe[RD_LAT-1];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] xf(input int m, input logic [31:0] d);
    case (m)
      0:       return d;
      1:       return ~d;
      2:       return d + 32'd1;
      default: return {d[15:0], d[31:16]};
    endcase
  endfunction

  // Model: a run is a count of enabled edges since the accepting start edge.
  // Word k occupies edges 1+D+k*(RD_LAT+2) .. +RD_LAT+1; the write shows RD_LAT edges in.
  bit m_run, m_err, m_rdy, m_done, m_bad;
  int m_e, m_d, m_len, m_thr, m_mode;

  initial begin
    forever begin
      @(posedge clk or negedge rst_a);
      if (!rst_a) begin
        m_run = 0; m_err = 0; m_rdy = 0; m_done = 0;
      end else if (en_s) begin
        m_done = 0;
        if (!m_run) begin
          if (start) begin
            m_run  = 1;
            m_e    = 0;
            m_err  = 0;
            m_rdy  = 0;
            m_d    = confReg[0] ? int'(confReg[31:1]) * TPM + 1 : 0;
            m_len  = (confReg[47:32] == 16'd0) ? 64 : int'(confReg[47:32]);
            m_bad  = (m_len > 64);
            m_thr  = int'(confReg[55:48]);
            m_mode = int'(confReg[57:56]);
          end
        end else begin
          m_e++;
          if (abort) begin
            m_run = 0; m_rdy = 0;
          end else if (m_bad) begin
            m_run = 0; m_err = 1;
          end else begin
            if (m_thr != 0 && m_thr <= m_len && m_e == 1 + m_d + m_thr * (RD_LAT + 2)) m_rdy = 1;
            if (m_e == 1 + m_d + m_len * (RD_LAT + 2)) begin
              m_run = 0; m_done = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int k, ph;
    logic xen;
    logic [5:0] xa;
    logic [31:0] xd;
    xen = 1'b0; xa = 6'd0; xd = 32'd0;
    if (m_run && m_e >= 1 + m_d) begin
      k   = (m_e - 1 - m_d) / (RD_LAT + 2);
      ph  = (m_e - 1 - m_d) % (RD_LAT + 2);
      xa  = 6'(k);
      xen = (ph == RD_LAT);
      if (xen) xd = xf(m_mode, mem[k]);
    end
    chk("cyc busy_f", {31'd0, busy_f}, {31'd0, m_run});
    chk("cyc enWR", {31'd0, enWR}, {31'd0, xen});
    chk("cyc addrRD", {26'd0, addrRD}, {26'd0, xa});
    chk("cyc addrWR", {26'd0, addrWR}, {26'd0, xa});
    chk("cyc dataWR", dataWR, xd);
    chk("cyc done_f", {31'd0, done_f}, {31'd0, m_done});
    chk("cyc data_read", {31'd0, data_read}, {31'd0, m_done});
    chk("cyc data_rdy", {31'd0, data_rdy}, {31'd0, m_rdy});
    chk("cyc err_f", {31'd0, err_f}, {31'd0, m_err});
  end

  int nwr, done_c, rdy_c, first_wr, last_addr, busy0, err0, drop_c;
  logic [31:0] wr_data [64];
  logic [5:0]  wr_addr [64];

  task automatic start_run(input logic [31:0] w0, input logic [31:0] w1, input logic with_abort);
    confReg = {w1, w0};
    @(posedge clk); #1 start = 1'b1; abort = with_abort;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
  endtask

  // Observes one run cycle by cycle; cycle 0 is the cycle after the start edge.
  task automatic run_log(input int max_c, input int start_at);
    nwr = 0; done_c = -1; rdy_c = -1; first_wr = -1; last_addr = -1; drop_c = -1;
    busy0 = -1; err0 = -1;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      start = (c == start_at);
      if (c == 0) begin busy0 = int'(busy_f); err0 = int'(err_f); end
      if (enWR) begin
        if (nwr < 64) begin wr_addr[nwr] = addrWR; wr_data[nwr] = dataWR; end
        if (first_wr < 0) first_wr = c;
        last_addr = int'(addrWR);
        nwr++;
      end
      if (data_rdy && rdy_c < 0) rdy_c = c;
      if (done_f) begin done_c = c; break; end
      if (!busy_f) begin drop_c = c; break; end
    end
    start = 1'b0;
  endtask

  logic [31:0] mode_exp [4];
  int c6, w6, d6;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; en_s = 1'b1; start = 1'b0; abort = 1'b0; confReg = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h10 + i;
    mode_exp[0] = 32'h0000FFFF; mode_exp[1] = 32'hFFFF0000;
    mode_exp[2] = 32'h00010000; mode_exp[3] = 32'hFFFF0000;
    repeat (2) @(negedge clk);
    chk("reset busy_f", {31'd0, busy_f}, 0);
    chk("reset enWR", {31'd0, enWR}, 0);
    chk("reset addrRD", {26'd0, addrRD}, 0);
    chk("reset err_f", {31'd0, err_f}, 0);
    #2 rst_a = 1'b1;

    // Basic copy: LEN=4, pass mode, 0x10.. at 0..3, done on cycle 13.
    start_run(32'h0, 32'h0000_0004, 1'b0);
    run_log(60, -1);
    chk("t1 writes", nwr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1 data", wr_data[i], 32'h10 + i);
      chk("t1 addr", {26'd0, wr_addr[i]}, i);
    end
    chk("t1 done cycle", done_c, 13);
    chk("t1 no data_rdy", rdy_c, -1);

    // Abort while idle must do nothing.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle abort busy", {31'd0, busy_f}, 0);

    // Transform modes on 0x0000FFFF; RDY_THR=5 > LEN so data_rdy stays low; mode 3 also carries abort with start.
    mem[0] = 32'h0000FFFF;
    for (int m = 0; m < 4; m++) begin
      start_run(32'h0, (32'(m) << 24) | 32'h0005_0001, m == 3);
      run_log(20, -1);
      chk("t2 writes", nwr, 1);
      chk("t2 mode data", wr_data[0], mode_exp[m]);
      chk("t2 done cycle", done_c, 4);
    end

    // Delay: 3 ms of 10 ticks -> 31 DELAY cycles; first write on cycle 33. RDY_THR==LEN.
    for (int i = 0; i < 64; i++) mem[i] = 32'h10 + i;
    start_run(32'h0000_0007, 32'h0002_0002, 1'b0);
    run_log(80, -1);
    chk("t3 first write", first_wr, 33);
    chk("t3 done cycle", done_c, 38);
    chk("t3 rdy with done", rdy_c, 38);
    start_run(32'h0000_0001, 32'h0000_0001, 1'b0);
    run_log(20, -1);
    chk("t3 zero-ms first write", first_wr, 3);
    chk("t3 zero-ms done", done_c, 5);

    // Full depth with RDY_THR=9 and an ignored start mid-run.
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i * 3);
    start_run(32'h0, 32'h0009_0000, 1'b0);
    run_log(300, 50);
    chk("t4 writes", nwr, 64);
    chk("t4 last addr", last_addr, 63);
    chk("t4 last data", wr_data[63], 32'hA500_00BD);
    chk("t4 rdy cycle", rdy_c, 28);
    chk("t4 done cycle", done_c, 193);

    // LEN=65 is illegal.
    start_run(32'h0, 32'h0000_0041, 1'b0);
    run_log(10, -1);
    chk("t5 busy at cfg", busy0, 1);
    chk("t5 busy drop", drop_c, 1);
    chk("t5 no writes", nwr, 0);
    repeat (2) @(negedge clk);
    chk("t5 err held", {31'd0, err_f}, 1);
    start_run(32'h0, 32'h0000_0001, 1'b0);
    run_log(20, -1);
    chk("t5 err cleared", err0, 0);
    chk("t5 recovery done", done_c, 4);

    // Abort after 2nd write with an en_s freeze; LEN=8, RDY_THR=1.
    start_run(32'h0, 32'h0001_0008, 1'b0);
    c6 = 0;
    do begin @(negedge clk); c6++; end while (!enWR && c6 < 20);
    chk("t6 first write", {31'd0, enWR}, 1);
    @(negedge clk);
    en_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6 frozen addrRD", {26'd0, addrRD}, 0);
    chk("t6 frozen busy", {31'd0, busy_f}, 1);
    chk("t6 frozen rdy", {31'd0, data_rdy}, 0);
    en_s = 1'b1;
    c6 = 0;
    do begin @(negedge clk); c6++; end while (!enWR && c6 < 20);
    chk("t6 second write", {31'd0, enWR}, 1);
    chk("t6 second addr", {26'd0, addrWR}, 1);
    chk("t6 rdy before abort", {31'd0, data_rdy}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6 abort busy", {31'd0, busy_f}, 0);
    chk("t6 abort addrRD", {26'd0, addrRD}, 0);
    chk("t6 abort rdy", {31'd0, data_rdy}, 0);
    w6 = 0; d6 = 0;
    repeat (20) begin
      @(negedge clk);
      if (enWR) w6++;
      if (done_f) d6++;
    end
    chk("t6 writes after abort", w6, 0);
    chk("t6 done after abort", d6, 0);

    // Asynchronous reset mid-run, then a clean run in mode 2.
    start_run(32'h0, 32'h0000_0004, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("t7 async busy", {31'd0, busy_f}, 0);
    chk("t7 async addrRD", {26'd0, addrRD}, 0);
    @(negedge clk);
    #2 rst_a = 1'b1;
    start_run(32'h0, 32'h0200_0004, 1'b0);
    run_log(60, -1);
    chk("t7 done cycle", done_c, 13);
    chk("t7 data", wr_data[0], 32'hA500_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
